// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: oversampling tick generator, start/data/stop framing FSM
// and a held valid/ready byte output with frame-error and overrun pulses.
module uart_rx_ctrl #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int TICK_DIV   = CLK_FREQ / (BAUD * OVERSAMPLE)
) (
   input  logic       clk,
   input  logic       rst,
   output logic       oversampling_tick,
   input  logic       rxd_bit,
   output logic [7:0] data,
   output logic       data_valid,
   input  logic       data_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = $clog2(OVERSAMPLE);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [TW-1:0]   tick_cnt;
   logic [SW-1:0]   sample_cnt;
   logic [SW-1:0]   cnt_next;
   logic [2:0]      bit_idx;
   logic [2:0]      idx_next;
   logic [7:0]      shreg;
   logic [7:0]      shreg_next;
   logic            deliver;
   logic            stop_bad;

   assign oversampling_tick = (tick_cnt == TW'(TICK_DIV - 1));
   assign busy              = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (oversampling_tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sample_cnt <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
      end else begin
         state      <= state_next;
         sample_cnt <= cnt_next;
         bit_idx    <= idx_next;
         shreg      <= shreg_next;
      end
   end

   // Start bit is re-checked at its midpoint; every later sample lands mid-bit.
   always_comb begin
      state_next = state;
      cnt_next   = sample_cnt;
      idx_next   = bit_idx;
      shreg_next = shreg;
      deliver    = 1'b0;
      stop_bad   = 1'b0;
      if (oversampling_tick) begin
         case (state)
            IDLE: begin
               if (!rxd_bit) begin
                  state_next = START;
                  cnt_next   = '0;
               end
            end
            START: begin
               if (sample_cnt == SW'(OVERSAMPLE / 2 - 1)) begin
                  cnt_next = '0;
                  if (!rxd_bit) begin
                     state_next = DATA;
                     idx_next   = '0;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  cnt_next = sample_cnt + 1'b1;
               end
            end
            DATA: begin
               if (sample_cnt == SW'(OVERSAMPLE - 1)) begin
                  shreg_next = {rxd_bit, shreg[7:1]};
                  cnt_next   = '0;
                  idx_next   = bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state_next = STOP;
                  end
               end else begin
                  cnt_next = sample_cnt + 1'b1;
               end
            end
            STOP: begin
               if (sample_cnt == SW'(OVERSAMPLE - 1)) begin
                  cnt_next   = '0;
                  state_next = IDLE;
                  if (rxd_bit) begin
                     deliver = 1'b1;
                  end else begin
                     stop_bad = 1'b1;
                  end
               end else begin
                  cnt_next = sample_cnt + 1'b1;
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // A byte accepted in the delivery cycle frees the slot, so the new byte replaces it.
   always_ff @(posedge clk) begin
      if (rst) begin
         data       <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         overrun   <= 1'b0;
         if (deliver) begin
            if (!data_valid || data_ready) begin
               data       <= shreg;
               data_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl: 16x oversampling, TICK_DIV=10,
// rxd_bit driven tick-aligned so every sample point is known exactly.
module tb_uart_rx_ctrl;

   logic       clk;
   logic       rst;
   logic       oversampling_tick;
   logic       rxd_bit;
   logic [7:0] data;
   logic       data_valid;
   logic       data_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int vectors    = 0;
   int miscompares = 0;

   uart_rx_ctrl #(
      .CLK_FREQ  (1_600_000),
      .BAUD      (10_000),
      .OVERSAMPLE(16)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .oversampling_tick(oversampling_tick),
      .rxd_bit          (rxd_bit),
      .data             (data),
      .data_valid       (data_valid),
      .data_ready       (data_ready),
      .frame_err        (frame_err),
      .overrun          (overrun),
      .busy             (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stops at the negedge of the next cycle in which oversampling_tick is high.
   task automatic wait_tick();
      int guard;
      guard = 0;
      @(negedge clk);
      while (oversampling_tick !== 1'b1 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (oversampling_tick !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL tick_timeout: tick=%b required 1 within 40 cycles", oversampling_tick);
      end
   endtask

   task automatic hold_line(input logic b, input int n);
      rxd_bit = b;
      repeat (n) begin
         wait_tick();
         @(posedge clk);
         #1;
      end
   endtask

   // Returns at the negedge of the stop-sample tick cycle, before that edge.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      hold_line(1'b1, 1);
      hold_line(1'b0, 16);
      for (int i = 0; i < 8; i++) hold_line(b[i], 16);
      hold_line(stop_bit, 8);
      wait_tick();
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      rxd_bit    = 1'b1;
      data_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (data_valid !== 1'b0 || data !== 8'h00 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: valid=%b data=%h busy=%b required 0 00 0", data_valid, data, busy);
      end
      vectors++;
      if (frame_err !== 1'b0 || overrun !== 1'b0 || oversampling_tick !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_flags: ferr=%b ovr=%b tick=%b required 0 0 0", frame_err, overrun, oversampling_tick);
      end
      rst = 1'b0;
      for (int c = 1; c <= 50; c++) begin
         if (c > 1) @(negedge clk);
         vectors++;
         if (oversampling_tick !== ((c % 10) == 0)) begin
            miscompares++;
            $display("[TB] FAIL tick_period cycle %0d: tick=%b required %b", c, oversampling_tick, (c % 10) == 0);
         end
      end
   endtask

   task automatic test_nominal();
      send_frame(8'hA5, 1'b1);
      vectors++;
      if (data_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL nominal_pre_valid: valid=%b required 0", data_valid);
      end
      @(negedge clk);
      vectors++;
      if (data_valid !== 1'b1 || data !== 8'hA5 || frame_err !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL nominal_deliver: valid=%b data=%h ferr=%b required 1 a5 0", data_valid, data, frame_err);
      end
      repeat (5) @(negedge clk);
      vectors++;
      if (data_valid !== 1'b1 || data !== 8'hA5) begin
         miscompares++;
         $display("[TB] FAIL nominal_hold: valid=%b data=%h required 1 a5", data_valid, data);
      end
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      vectors++;
      if (data_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL nominal_accept: valid=%b required 0", data_valid);
      end
   endtask

   task automatic test_false_start();
      hold_line(1'b1, 1);
      hold_line(1'b0, 1);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL false_start_busy: busy=%b required 1", busy);
      end
      hold_line(1'b0, 3);
      hold_line(1'b1, 4);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL false_start_tick7: busy=%b required 1", busy);
      end
      hold_line(1'b1, 1);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || data_valid !== 1'b0 || frame_err !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL false_start_idle: busy=%b valid=%b ferr=%b required 0 0 0", busy, data_valid, frame_err);
      end
   endtask

   task automatic test_frame_err();
      send_frame(8'h3C, 1'b0);
      @(negedge clk);
      rxd_bit = 1'b1;
      vectors++;
      if (frame_err !== 1'b1 || data_valid !== 1'b0 || overrun !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL frame_err_pulse: ferr=%b valid=%b ovr=%b required 1 0 0", frame_err, data_valid, overrun);
      end
      @(negedge clk);
      vectors++;
      if (frame_err !== 1'b0 || data_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL frame_err_width: ferr=%b valid=%b required 0 0", frame_err, data_valid);
      end
      hold_line(1'b1, 20);
      send_frame(8'h81, 1'b1);
      @(negedge clk);
      vectors++;
      if (data_valid !== 1'b1 || data !== 8'h81 || frame_err !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL frame_err_recover: valid=%b data=%h ferr=%b required 1 81 0", data_valid, data, frame_err);
      end
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      vectors++;
      if (data_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL frame_err_accept: valid=%b required 0", data_valid);
      end
   endtask

   task automatic test_overrun();
      send_frame(8'h11, 1'b1);
      @(negedge clk);
      vectors++;
      if (data_valid !== 1'b1 || data !== 8'h11) begin
         miscompares++;
         $display("[TB] FAIL overrun_first: valid=%b data=%h required 1 11", data_valid, data);
      end
      send_frame(8'h22, 1'b1);
      @(negedge clk);
      vectors++;
      if (overrun !== 1'b1 || data !== 8'h11 || data_valid !== 1'b1 || frame_err !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL overrun_pulse: ovr=%b data=%h valid=%b ferr=%b required 1 11 1 0", overrun, data, data_valid, frame_err);
      end
      @(negedge clk);
      vectors++;
      if (overrun !== 1'b0 || data !== 8'h11) begin
         miscompares++;
         $display("[TB] FAIL overrun_width: ovr=%b data=%h required 0 11", overrun, data);
      end
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      vectors++;
      if (data_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL overrun_accept: valid=%b required 0", data_valid);
      end
   endtask

   task automatic test_back_to_back();
      send_frame(8'h33, 1'b1);
      @(negedge clk);
      vectors++;
      if (data_valid !== 1'b1 || data !== 8'h33) begin
         miscompares++;
         $display("[TB] FAIL b2b_first: valid=%b data=%h required 1 33", data_valid, data);
      end
      hold_line(1'b1, 6);
      send_frame(8'h44, 1'b1);
      vectors++;
      if (data_valid !== 1'b1 || data !== 8'h33) begin
         miscompares++;
         $display("[TB] FAIL b2b_pre: valid=%b data=%h required 1 33", data_valid, data);
      end
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      vectors++;
      if (data_valid !== 1'b1 || data !== 8'h44 || overrun !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL b2b_replace: valid=%b data=%h ovr=%b required 1 44 0", data_valid, data, overrun);
      end
      @(negedge clk);
      vectors++;
      if (data_valid !== 1'b1 || data !== 8'h44 || overrun !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL b2b_hold: valid=%b data=%h ovr=%b required 1 44 0", data_valid, data, overrun);
      end
   endtask

   task automatic test_reset_mid_frame();
      hold_line(1'b1, 1);
      hold_line(1'b0, 16);
      hold_line(1'b1, 16 * 3 + 5);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL mid_frame_busy: busy=%b required 1", busy);
      end
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (data_valid !== 1'b0 || data !== 8'h00 || busy !== 1'b0 || oversampling_tick !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL mid_frame_reset: valid=%b data=%h busy=%b tick=%b required 0 00 0 0", data_valid, data, busy, oversampling_tick);
      end
      vectors++;
      if (frame_err !== 1'b0 || overrun !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL mid_frame_flags: ferr=%b ovr=%b required 0 0", frame_err, overrun);
      end
      rst = 1'b0;
      hold_line(1'b1, 2);
      send_frame(8'h5A, 1'b1);
      @(negedge clk);
      vectors++;
      if (data_valid !== 1'b1 || data !== 8'h5A || frame_err !== 1'b0 || overrun !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL mid_frame_recover: valid=%b data=%h ferr=%b ovr=%b required 1 5a 0 0", data_valid, data, frame_err, overrun);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_false_start();
      test_frame_err();
      test_overrun();
      test_back_to_back();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      vectors++;
      miscompares++;
      $display("[TB] FAIL watchdog: run time exceeded 2 ms");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
